// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D-cache memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DFLT = 28;   // line address, byte address bits 31:4
    localparam int DATA_W_DFLT = 128;  // one cache line

    // Port identifiers, also the encoding of the last_grant register.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

    // Busy state that belongs to a given port.
    function automatic arb_state_t busy_state(input logic port);
        return (port == PORT_D) ? BUSY_D : BUSY_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter used for per-port wait-cycle statistics.
// Latency: count updates on the clock edge following a cycle with inc=1.
// Backpressure: none; holds at all-ones once saturated, cleared only by reset.
//
// Ports: clk, rst (async, active-high), inc (count this cycle), cnt (value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one slow memory port between the I-cache and the D-cache, one command at a time.
// Latency: grant sampled in IDLE drives mem_* next cycle; x_ready is combinational with mem_ready.
// Backpressure: requesters hold strobes until their ready pulse; the loser simply waits.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_read/i_write/i_addr/i_wdata -> i_rdata/i_ready   I-cache request and completion
//   d_read/d_write/d_addr/d_wdata -> d_rdata/d_ready   D-cache request and completion
//   mem_read/mem_write/mem_addr/mem_wdata              registered command to memory
//   mem_rdata/mem_ready                                memory read line and completion pulse
//   i_wait_cnt/d_wait_cnt                              saturating cycles spent waiting for a grant
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DFLT,
    parameter int DATA_W     = DATA_W_DFLT,
    parameter int D_PRIORITY = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic [CNT_W-1:0]  i_wait_cnt,
    output logic [CNT_W-1:0]  d_wait_cnt
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              last_grant;

    logic              i_req;
    logic              d_req;
    logic              grant_vld;
    logic              grant_port;
    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              cmd_done;
    logic              i_wait_inc;
    logic              d_wait_inc;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

    // Arbitration: only IDLE can grant. On contention the port not named by
    // last_grant wins, so after reset (last_grant = I) the D port goes first.
    always_comb begin
        grant_vld  = 1'b0;
        grant_port = PORT_I;
        if (state == IDLE) begin
            if (i_req && d_req) begin
                grant_vld = 1'b1;
                if (D_PRIORITY != 0) begin
                    grant_port = PORT_D;
                end else begin
                    grant_port = (last_grant == PORT_I) ? PORT_D : PORT_I;
                end
            end else if (d_req) begin
                grant_vld  = 1'b1;
                grant_port = PORT_D;
            end else if (i_req) begin
                grant_vld  = 1'b1;
                grant_port = PORT_I;
            end
        end
    end

    // Command source mux for the winning port.
    always_comb begin
        sel_read  = i_read;
        sel_write = i_write;
        sel_addr  = i_addr;
        sel_wdata = i_wdata;
        if (grant_port == PORT_D) begin
            sel_read  = d_read;
            sel_write = d_write;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end
    end

    // mem_ready only means something while a command is outstanding.
    assign cmd_done = mem_ready && ((state == BUSY_I) || (state == BUSY_D));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (grant_vld) state_nxt = busy_state(grant_port);
            BUSY_I: if (mem_ready) state_nxt = DRAIN;
            BUSY_D: if (mem_ready) state_nxt = DRAIN;
            DRAIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command register. A simultaneous read+write is forwarded as a write only.
    // Address and write data are left as they were on completion; only the
    // strobes qualify them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            last_grant <= PORT_I;
        end else if (grant_vld) begin
            mem_write <= sel_write;
            mem_read  <= sel_read & ~sel_write;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
        end else if (cmd_done) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            last_grant <= (state == BUSY_D) ? PORT_D : PORT_I;
        end
    end

    // Completion goes only to the owner, with no added latency.
    assign i_ready = mem_ready && (state == BUSY_I);
    assign d_ready = mem_ready && (state == BUSY_D);

    // Read data is shared; each cache qualifies it with its own ready.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // A port is waiting when it requests, does not own the memory and is not
    // being granted this very cycle. Excluding the grant cycle means an
    // uncontended request accumulates no wait time.
    assign i_wait_inc = i_req && (state != BUSY_I) && !(grant_vld && (grant_port == PORT_I));
    assign d_wait_inc = d_req && (state != BUSY_D) && !(grant_vld && (grant_port == PORT_D));

    sat_counter #(.W(CNT_W)) u_i_wait (
        .clk (clk),
        .rst (rst),
        .inc (i_wait_inc),
        .cnt (i_wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_d_wait (
        .clk (clk),
        .rst (rst),
        .inc (d_wait_inc),
        .cnt (d_wait_cnt)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboard of expected memory
// commands and completions, table-driven request patterns, and hand-written
// sequences for contention, write readback, reset mid-flight and fixed priority.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW  = 28;
    localparam int DW  = 128;
    localparam int CW  = 16;
    localparam int PCW = 4;
    localparam logic [DW-1:0] WR_LINE = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Round-robin instance
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
    logic          i_ready, d_ready;
    logic          mem_read, mem_write, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [CW-1:0] i_wait_cnt, d_wait_cnt;

    // Fixed-priority instance
    logic           p_i_read = 1'b0, p_d_read = 1'b0;
    logic [AW-1:0]  p_i_addr = 28'h0AA, p_d_addr = 28'h0BB;
    logic [DW-1:0]  p_wdata = '0, p_mem_rdata = '0;
    logic [DW-1:0]  p_i_rdata, p_d_rdata, p_mem_wdata;
    logic           p_i_ready, p_d_ready, p_mem_read, p_mem_write;
    logic           p_mem_ready = 1'b0;
    logic [AW-1:0]  p_mem_addr;
    logic [PCW-1:0] p_i_wait_cnt, p_d_wait_cnt;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_PRIORITY(0), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_PRIORITY(1), .CNT_W(PCW)) dut_p (
        .clk(clk), .rst(rst),
        .i_read(p_i_read), .i_write(1'b0), .i_addr(p_i_addr), .i_wdata(p_wdata),
        .i_rdata(p_i_rdata), .i_ready(p_i_ready),
        .d_read(p_d_read), .d_write(1'b0), .d_addr(p_d_addr), .d_wdata(p_wdata),
        .d_rdata(p_d_rdata), .d_ready(p_d_ready),
        .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_addr(p_mem_addr),
        .mem_wdata(p_mem_wdata), .mem_rdata(p_mem_rdata), .mem_ready(p_mem_ready),
        .i_wait_cnt(p_i_wait_cnt), .d_wait_cnt(p_d_wait_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slow memory model ----------------
    logic [DW-1:0] mem_arr [logic [AW-1:0]];
    logic mem_en    = 1'b1;
    logic model_rdy = 1'b0;
    logic force_rdy = 1'b0;
    int   mem_lat   = 4;
    int   mcnt      = 0;

    assign mem_ready = model_rdy | force_rdy;

    function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {4{4'h5, a}};
    endfunction

    // Completion mem_lat cycles after the command first appears.
    always @(posedge clk) begin
        #1;
        if (rst || !mem_en) begin
            mcnt      = 0;
            model_rdy = 1'b0;
        end else if (model_rdy) begin
            model_rdy = 1'b0;
            mcnt      = 0;
        end else if (mem_read || mem_write) begin
            mcnt++;
            if (mcnt >= mem_lat) begin
                if (mem_write) mem_arr[mem_addr] = mem_wdata;
                else           mem_rdata = line_of(mem_addr);
                model_rdy = 1'b1;
            end
        end
    end

    // One-cycle memory for the priority instance.
    always @(posedge clk) begin
        #1;
        if (rst)                            p_mem_ready = 1'b0;
        else if (p_mem_ready)               p_mem_ready = 1'b0;
        else if (p_mem_read || p_mem_write) p_mem_ready = 1'b1;
    end

    int p_i_rdy_n = 0;
    int p_d_rdy_n = 0;
    always @(negedge clk) begin
        if (p_i_ready) p_i_rdy_n++;
        if (p_d_ready) p_d_rdy_n++;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic          port;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input logic port, input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd);
        exp_t e;
        e.port = port; e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd;
        exp_q.push_back(e);
    endtask

    logic          cmd_prev = 1'b0;
    logic          h_rd, h_wr;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wd;

    always @(negedge clk) begin
        if (rst) begin
            cmd_prev = 1'b0;
        end else begin
            if ((mem_read || mem_write) && !cmd_prev) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cmd_unexpected: got rd=%0b wr=%0b addr=%0h expected no command",
                             mem_read, mem_write, mem_addr);
                end else begin
                    chk("cmd_rd", mem_read, exp_q[0].rd);
                    chk("cmd_wr", mem_write, exp_q[0].wr);
                    chk("cmd_addr", mem_addr, exp_q[0].addr);
                    if (exp_q[0].wr) chk("cmd_wdata", mem_wdata, exp_q[0].wdata);
                end
                h_rd = mem_read; h_wr = mem_write; h_addr = mem_addr; h_wd = mem_wdata;
            end else if (mem_read || mem_write) begin
                chk("cmd_hold", ({mem_read, mem_write, mem_addr, mem_wdata} == {h_rd, h_wr, h_addr, h_wd}), 1);
            end
            if (i_ready || d_ready) begin
                chk("ready_excl", i_ready && d_ready, 0);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ready_unexpected: got i_ready=%0b d_ready=%0b expected none", i_ready, d_ready);
                end else begin
                    chk("ready_port", d_ready, exp_q[0].port);
                    if (exp_q[0].rd) chk("rdata", d_ready ? d_rdata : i_rdata, line_of(exp_q[0].addr));
                    void'(exp_q.pop_front());
                end
            end
            cmd_prev = mem_read || mem_write;
        end
    end

    // ---------------- request driver ----------------
    // rd1/wr1 are the strobes expected on the first granted command.
    task automatic run_req(input logic ir, input logic iw, input logic dr, input logic dw,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input logic [DW-1:0] iwd, input logic [DW-1:0] dwd,
                           input logic d_first, input logic rd1, input logic wr1);
        logic ireq, dreq;
        int   rdy_k, cmd_k, first_k;
        bit   done;
        ireq = ir | iw;
        dreq = dr | dw;
        if (ireq && dreq) begin
            if (d_first) begin
                push_exp(PORT_D, rd1, wr1, da, dwd);
                push_exp(PORT_I, ir & ~iw, iw, ia, iwd);
            end else begin
                push_exp(PORT_I, rd1, wr1, ia, iwd);
                push_exp(PORT_D, dr & ~dw, dw, da, dwd);
            end
        end else if (dreq) begin
            push_exp(PORT_D, rd1, wr1, da, dwd);
        end else begin
            push_exp(PORT_I, rd1, wr1, ia, iwd);
        end
        @(negedge clk);
        i_read = ir; i_write = iw; i_addr = ia; i_wdata = iwd;
        d_read = dr; d_write = dw; d_addr = da; d_wdata = dwd;
        rdy_k = -1; cmd_k = -1; first_k = -1; done = 0;
        for (int k = 1; k <= 200 && !done; k++) begin
            @(negedge clk);
            if ((mem_read || mem_write) && first_k < 0) first_k = k;
            if (rdy_k >= 0 && cmd_k < 0 && (mem_read || mem_write)) cmd_k = k;
            if ((i_ready || d_ready) && rdy_k < 0) rdy_k = k;
            if (i_ready) begin i_read = 1'b0; i_write = 1'b0; end
            if (d_ready) begin d_read = 1'b0; d_write = 1'b0; end
            if (!(i_read || i_write || d_read || d_write)) done = 1;
        end
        chk("req_done", done, 1);
        if (!done) begin
            i_read = 0; i_write = 0; d_read = 0; d_write = 0;
            exp_q.delete();
        end
        chk("grant_latency", first_k, 1);
        // ready cycle, DRAIN, IDLE sample, then the next command is visible
        if (ireq && dreq) chk("b2b_spacing", cmd_k - rdy_k, 3);
        repeat (2) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    typedef struct {
        logic ir, iw, dr, dw;
        logic d_first;
        logic rd1, wr1;
    } vec_t;

    vec_t vecs[8];
    int   dn;
    bit   seq_done;

    initial begin
        // last_grant is I after the opening contention pair.
        vecs[0] = '{ir:0, iw:0, dr:1, dw:0, d_first:1, rd1:1, wr1:0}; // single D read
        vecs[1] = '{ir:1, iw:0, dr:1, dw:0, d_first:0, rd1:1, wr1:0}; // lg=D -> I first
        vecs[2] = '{ir:0, iw:1, dr:1, dw:1, d_first:0, rd1:0, wr1:1}; // I write first, D conflict
        vecs[3] = '{ir:0, iw:0, dr:1, dw:1, d_first:1, rd1:0, wr1:1}; // conflict alone: write only
        vecs[4] = '{ir:1, iw:1, dr:1, dw:0, d_first:0, rd1:0, wr1:1}; // I conflict wins
        vecs[5] = '{ir:1, iw:0, dr:0, dw:0, d_first:0, rd1:1, wr1:0}; // single I read
        vecs[6] = '{ir:1, iw:0, dr:1, dw:0, d_first:1, rd1:1, wr1:0}; // lg=I -> D first
        vecs[7] = '{ir:0, iw:1, dr:0, dw:0, d_first:0, rd1:0, wr1:1}; // single I write

        rst = 1'b1;
        i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_i_wait", i_wait_cnt, 0);
        chk("rst_d_wait", d_wait_cnt, 0);
        rst = 1'b0;

        // Contention from reset: D first, then I. I waits for the D busy
        // time (mem_lat), the DRAIN cycle and the IDLE cycle it lost.
        run_req(1, 0, 1, 0, 28'h0000011, 28'h0000022, '0, '0, 1, 1, 0);
        chk("first_pair_d_wait", d_wait_cnt, 0);
        chk("first_pair_i_wait", i_wait_cnt, mem_lat + 2);

        for (int r = 0; r < 8; r++) begin
            run_req(vecs[r].ir, vecs[r].iw, vecs[r].dr, vecs[r].dw,
                    28'h0000100 + AW'(r), (r == 0) ? 28'h0000010 : 28'h0000200 + AW'(r),
                    {$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom},
                    vecs[r].d_first, vecs[r].rd1, vecs[r].wr1);
        end

        // Continuous contention with D never releasing: D, I, D.
        push_exp(PORT_D, 1, 0, 28'h0000300, '0);
        push_exp(PORT_I, 1, 0, 28'h0000301, '0);
        push_exp(PORT_D, 1, 0, 28'h0000300, '0);
        @(negedge clk);
        i_read = 1; i_addr = 28'h0000301; d_read = 1; d_addr = 28'h0000300;
        dn = 0; seq_done = 0;
        for (int k = 0; k < 300 && !seq_done; k++) begin
            @(negedge clk);
            if (i_ready) i_read = 0;
            if (d_ready) begin dn++; if (dn == 2) d_read = 0; end
            if (!i_read && !d_read) seq_done = 1;
        end
        chk("rr_seq_done", seq_done, 1);
        i_read = 0; d_read = 0;
        repeat (2) @(negedge clk);
        chk("rr_sb_empty", exp_q.size(), 0);

        // Write a known line, then read it back through the D port.
        run_req(0, 0, 0, 1, '0, 28'h0000040, '0, WR_LINE, 1, 0, 1);
        chk("wr_mem_updated", mem_arr.exists(28'h0000040) ? mem_arr[28'h0000040] : '0, WR_LINE);
        run_req(0, 0, 1, 0, '0, 28'h0000040, '0, '0, 1, 1, 0);

        // Reset while an I read is outstanding.
        mem_lat = 20;
        push_exp(PORT_I, 1, 0, 28'h0000077, '0);
        @(negedge clk);
        i_read = 1; i_addr = 28'h0000077;
        repeat (2) @(negedge clk);
        chk("rst_pre_mem_read", mem_read, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_mem_read", mem_read, 0);
        chk("rst_async_mem_addr", mem_addr, 0);
        i_read = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mem_en = 1'b0;
        @(negedge clk);
        force_rdy = 1'b1;
        #1;
        chk("late_rdy_i_ready", i_ready, 0);
        chk("late_rdy_d_ready", d_ready, 0);
        @(negedge clk);
        force_rdy = 1'b0;
        chk("late_rdy_no_cmd", mem_read | mem_write, 0);
        mem_en = 1'b1;
        mem_lat = 4;

        // Fixed D priority: D always wins, I waits and saturates.
        @(negedge clk);
        p_i_read = 1; p_d_read = 1;
        repeat (6) @(negedge clk);
        chk("prio_i_wait_6", p_i_wait_cnt, 6);
        repeat (60) @(negedge clk);
        chk("prio_i_wait_sat", p_i_wait_cnt, 4'hF);
        chk("prio_no_i_ready", p_i_rdy_n, 0);
        chk("prio_d_grants", p_d_rdy_n >= 20, 1);
        p_i_read = 0; p_d_read = 0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
